// File: rtl/mem_access_ctrl_pkg.sv
// Shared d16 memory-bus definitions: sequencer state encodings, lane constants
// and the address helper used by both the initiator and the mem block.
package mem_access_ctrl_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] READ   = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    // Attributes of the accepted request that outlive the IDLE cycle.
    typedef struct packed {
        logic write;
        logic byte_acc;
        logic sgn;
        logic sel;
    } mem_req_t;

    // The memory is word addressed; bit 0 only selects the byte lane.
    function automatic logic [15:0] word_addr(input logic [15:0] byte_addr);
        return {1'b0, byte_addr[15:1]};
    endfunction

endpackage

// File: rtl/mem_access_ctrl_lane.sv
// Byte-lane extraction for d16 read data: word pass-through, or one lane
// zero/sign-extended to 16 bits. Purely combinational.
module mem_lane_extract
    import mem_access_ctrl_pkg::*;
(
    input  logic [15:0] rdata,
    input  logic        byte_mode,
    input  logic        lane_sel,
    input  logic        sign_ext,
    output logic [15:0] result
);

    logic [7:0] lane_byte;
    logic       fill_bit;

    assign lane_byte   = (lane_sel == LANE_HI) ? rdata[15:8] : rdata[7:0];
    assign fill_bit    = sign_ext & lane_byte[7];
    assign result[7:0] = byte_mode ? lane_byte : rdata[7:0];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_upper
            assign result[8 + gi] = byte_mode ? fill_bit : rdata[8 + gi];
        end
    endgenerate

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator side of the d16 data-memory bus: accepts one CPU load/store at a
// time, sequences en/write_enable with mem_wait stalls and a wait timeout.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic        req_signed,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [15:0] resp_rdata,
    output logic        mem_en,
    output logic        mem_write_enable,
    output logic        mem_byte_enable,
    output logic        mem_byte_select,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_wait
);

    // Abort fires on the edge that closes the TIMEOUT-th consecutive wait cycle.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [1:0]      state_reg, state_next;
    logic [TO_W-1:0] wait_cnt_reg, wait_cnt_next;
    mem_req_t        req_reg, req_next;
    logic            ready_reg, ready_next;
    logic            resp_valid_reg, resp_valid_next;
    logic            resp_err_reg, resp_err_next;
    logic [15:0]     resp_rdata_reg, resp_rdata_next;
    logic            mem_en_reg, mem_en_next;
    logic            mem_we_reg, mem_we_next;
    logic            mem_be_reg, mem_be_next;
    logic            mem_bs_reg, mem_bs_next;
    logic [15:0]     mem_addr_reg, mem_addr_next;
    logic [15:0]     mem_wdata_reg, mem_wdata_next;
    logic [15:0]     load_data;
    logic            timeout_hit;

    mem_lane_extract u_lane (
        .rdata     (mem_rdata),
        .byte_mode (req_reg.byte_acc),
        .lane_sel  (req_reg.sel),
        .sign_ext  (req_reg.sgn),
        .result    (load_data)
    );

    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_reg == TO_LAST);

    always_comb begin
        state_next      = state_reg;
        wait_cnt_next   = wait_cnt_reg;
        req_next        = req_reg;
        ready_next      = ready_reg;
        resp_valid_next = 1'b0;
        resp_err_next   = 1'b0;
        resp_rdata_next = resp_rdata_reg;
        mem_en_next     = mem_en_reg;
        mem_we_next     = mem_we_reg;
        mem_be_next     = mem_be_reg;
        mem_bs_next     = mem_bs_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;

        case (state_reg)
            IDLE: begin
                if (req_valid && ready_reg) begin
                    req_next.write    = req_write;
                    req_next.byte_acc = req_byte;
                    req_next.sgn      = req_signed;
                    req_next.sel      = req_addr[0];
                    mem_en_next       = 1'b1;
                    mem_we_next       = req_write;
                    mem_be_next       = req_byte;
                    mem_bs_next       = req_addr[0];
                    mem_addr_next     = word_addr(req_addr);
                    mem_wdata_next    = req_wdata;
                    ready_next        = 1'b0;
                    wait_cnt_next     = '0;
                    state_next        = ACCESS;
                end
            end

            ACCESS: begin
                if (mem_wait) begin
                    if (timeout_hit) begin
                        mem_en_next     = 1'b0;
                        mem_we_next     = 1'b0;
                        wait_cnt_next   = '0;
                        resp_valid_next = 1'b1;
                        resp_err_next   = 1'b1;
                        state_next      = RESP;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + TO_W'(1);
                    end
                end else begin
                    mem_en_next   = 1'b0;
                    mem_we_next   = 1'b0;
                    wait_cnt_next = '0;
                    if (req_reg.write) begin
                        resp_valid_next = 1'b1;
                        state_next      = RESP;
                    end else begin
                        state_next = READ;
                    end
                end
            end

            // The memory keeps presenting the word it registered during ACCESS.
            READ: begin
                if (mem_wait) begin
                    if (timeout_hit) begin
                        wait_cnt_next   = '0;
                        resp_valid_next = 1'b1;
                        resp_err_next   = 1'b1;
                        state_next      = RESP;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + TO_W'(1);
                    end
                end else begin
                    wait_cnt_next   = '0;
                    resp_rdata_next = load_data;
                    resp_valid_next = 1'b1;
                    state_next      = RESP;
                end
            end

            RESP: begin
                ready_next = 1'b1;
                state_next = IDLE;
            end

            default: begin
                mem_en_next = 1'b0;
                mem_we_next = 1'b0;
                ready_next  = 1'b1;
                state_next  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            wait_cnt_reg   <= '0;
            req_reg        <= '0;
            ready_reg      <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= '0;
            mem_en_reg     <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_be_reg     <= 1'b0;
            mem_bs_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            wait_cnt_reg   <= wait_cnt_next;
            req_reg        <= req_next;
            ready_reg      <= ready_next;
            resp_valid_reg <= resp_valid_next;
            resp_err_reg   <= resp_err_next;
            resp_rdata_reg <= resp_rdata_next;
            mem_en_reg     <= mem_en_next;
            mem_we_reg     <= mem_we_next;
            mem_be_reg     <= mem_be_next;
            mem_bs_reg     <= mem_bs_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
        end
    end

    assign req_ready        = ready_reg;
    assign resp_valid       = resp_valid_reg;
    assign resp_err         = resp_err_reg;
    assign resp_rdata       = resp_rdata_reg;
    assign mem_en           = mem_en_reg;
    assign mem_write_enable = mem_we_reg;
    assign mem_byte_enable  = mem_be_reg;
    assign mem_byte_select  = mem_bs_reg;
    assign mem_addr         = mem_addr_reg;
    assign mem_wdata        = mem_wdata_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a bus-side memory model answers the DUT while a
// per-transaction reference model predicts latency, bus fields and results.
module tb_mem_access_ctrl;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_byte = 1'b0;
    logic        req_signed = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_err;
    logic [15:0] resp_rdata;
    logic        mem_en;
    logic        mem_write_enable;
    logic        mem_byte_enable;
    logic        mem_byte_select;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_wait = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] bus_mem [0:31];
    logic [15:0] ref_mem [0:31];
    logic [15:0] bus_dout = '0;
    logic [15:0] exp_rdata = '0;

    mem_access_ctrl #(.TIMEOUT(T), .TO_W(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_byte         (req_byte),
        .req_signed       (req_signed),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_err         (resp_err),
        .resp_rdata       (resp_rdata),
        .mem_en           (mem_en),
        .mem_write_enable (mem_write_enable),
        .mem_byte_enable  (mem_byte_enable),
        .mem_byte_select  (mem_byte_select),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .mem_wait         (mem_wait)
    );

    always #5 clk = ~clk;

    // Behaviour of the d16 mem block as seen on the bus.
    assign mem_rdata = bus_dout;
    always @(posedge clk) begin
        if (mem_en && !mem_wait) begin
            if (mem_write_enable) begin
                if (!mem_byte_enable)
                    bus_mem[mem_addr[4:0]] <= mem_wdata;
                else if (mem_byte_select)
                    bus_mem[mem_addr[4:0]][15:8] <= mem_wdata[7:0];
                else
                    bus_mem[mem_addr[4:0]][7:0] <= mem_wdata[7:0];
            end else begin
                bus_dout <= bus_mem[mem_addr[4:0]];
            end
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [15:0] ref_load(input logic byte_op, input logic sgn_op,
                                             input logic [15:0] addr);
        int w, b;
        w = int'(ref_mem[addr[5:1]]);
        if (!byte_op) return 16'(w);
        b = addr[0] ? (w / 256) : (w % 256);
        if (sgn_op && b >= 128) b = b + 65280;
        return 16'(b);
    endfunction

    task automatic ref_store(input logic byte_op, input logic [15:0] addr, input logic [15:0] wdata);
        int w;
        w = int'(ref_mem[addr[5:1]]);
        if (!byte_op) w = int'(wdata);
        else if (addr[0]) w = (w % 256) + 256 * int'(wdata[7:0]);
        else w = (w / 256) * 256 + int'(wdata[7:0]);
        ref_mem[addr[5:1]] = 16'(w);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic do_txn(input logic wr_op, input logic byte_op, input logic sgn_op,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          input int wa, input int wr, input logic noise);
        int a_cyc, r_cyc, exp_lat, c, en_cnt;
        logic exp_err, seen;
        a_cyc   = (wa >= T) ? T : wa + 1;
        exp_err = (wa >= T);
        r_cyc   = 0;
        if (!wr_op && !exp_err) begin
            r_cyc   = (wr >= T) ? T : wr + 1;
            exp_err = (wr >= T);
        end
        exp_lat = a_cyc + r_cyc + 1;
        if (!exp_err) begin
            if (wr_op) ref_store(byte_op, addr, wdata);
            else exp_rdata = ref_load(byte_op, sgn_op, addr);
        end

        check("ready_idle", {15'd0, req_ready}, 16'd1);
        req_valid = 1'b1; req_write = wr_op; req_byte = byte_op;
        req_signed = sgn_op; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        if (noise) begin
            req_addr = 16'($urandom); req_wdata = 16'($urandom); req_write = ~wr_op;
        end else begin
            req_valid = 1'b0;
        end

        c = 1; seen = 1'b0; en_cnt = 0;
        while (!seen && c <= 40) begin
            if (c == 1) begin
                check("bus_ctl", {10'd0, req_ready, mem_en, mem_write_enable, mem_byte_enable,
                                  mem_byte_select, 1'b0},
                      {10'd0, 1'b0, 1'b1, wr_op, byte_op, addr[0], 1'b0});
                check("bus_addr", mem_addr, addr >> 1);
                check("bus_wdata", mem_wdata, wdata);
            end
            if (mem_en) en_cnt++;
            if (resp_valid) begin
                seen = 1'b1;
                req_valid = 1'b0;
                mem_wait = 1'b0;
                check("latency", 16'(c), 16'(exp_lat));
                check("resp_err", {15'd0, resp_err}, {15'd0, exp_err});
                check("resp_rdata", resp_rdata, exp_rdata);
                check("en_cycles", 16'(en_cnt), 16'(a_cyc));
            end else begin
                if (c <= a_cyc) mem_wait = (c <= wa);
                else if (c <= a_cyc + r_cyc) mem_wait = ((c - a_cyc) <= wr);
                else mem_wait = 1'b0;
                @(negedge clk);
                c++;
            end
        end
        if (!seen) begin
            check("resp_missing", 16'd0, 16'd1);
            req_valid = 1'b0;
            mem_wait = 1'b0;
        end
        @(negedge clk);
        check("resp_pulse", {15'd0, resp_valid}, 16'd0);
        $display("txn %s %s%s addr=%h wdata=%h wa=%0d wr=%0d err=%0d rdata=%h",
                 wr_op ? "ST" : "LD", byte_op ? "B" : "W", sgn_op ? "S" : "U",
                 addr, wdata, wa, wr, exp_err, resp_rdata);
    endtask

    function automatic int pick_wait();
        return ($urandom_range(0, 7) == 0) ? int'($urandom_range(T, T + 2))
                                           : int'($urandom_range(0, 3));
    endfunction

    initial begin
        logic bad_en, bad_vld;
        for (int i = 0; i < 32; i++) begin
            bus_mem[i] = 16'($urandom);
            ref_mem[i] = bus_mem[i];
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_ctl", {9'd0, req_ready, resp_valid, resp_err, mem_en, mem_write_enable,
                          mem_byte_enable, mem_byte_select}, 16'h0040);
        check("rst_rdata", resp_rdata, 16'h0000);
        check("rst_addr", mem_addr, 16'h0000);
        check("rst_wdata", mem_wdata, 16'h0000);

        do_txn(1, 0, 0, 16'h0010, 16'hBEEF, 0, 0, 0);
        check("mem_word8_a", bus_mem[8], 16'hBEEF);
        do_txn(0, 0, 0, 16'h0010, 16'h0000, 0, 0, 0);
        do_txn(1, 1, 0, 16'h0011, 16'hA512, 0, 0, 0);
        check("mem_word8_b", bus_mem[8], 16'h12EF);
        do_txn(0, 1, 1, 16'h0011, 16'h0000, 0, 0, 0);
        do_txn(0, 1, 1, 16'h0010, 16'h0000, 0, 0, 0);
        do_txn(0, 1, 0, 16'h0010, 16'h0000, 0, 0, 0);
        do_txn(0, 0, 0, 16'h0010, 16'h0000, 3, 0, 0);
        do_txn(0, 0, 0, 16'h0020, 16'h0000, 9, 0, 0);
        do_txn(0, 1, 1, 16'h0021, 16'h0000, 0, 9, 0);
        do_txn(1, 0, 0, 16'h0022, 16'h5A5A, 9, 0, 0);

        for (int n = 0; n < 150; n++) begin
            do_txn(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom_range(0, 63)),
                   16'($urandom), pick_wait(), pick_wait(), 1'($urandom));
        end
        for (int i = 0; i < 32; i++) check("final_mem", bus_mem[i], ref_mem[i]);

        // Reset while the controller sits in READ.
        req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_addr = 16'h0004;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ctl", {9'd0, req_ready, resp_valid, resp_err, mem_en, mem_write_enable,
                             mem_byte_enable, mem_byte_select}, 16'h0040);
        check("midrst_rdata", resp_rdata, 16'h0000);
        check("midrst_addr", mem_addr, 16'h0000);
        bad_en = 1'b0; bad_vld = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bad_en  |= mem_en;
            bad_vld |= resp_valid;
            @(negedge clk);
        end
        check("midrst_quiet", {14'd0, bad_en, bad_vld}, 16'd0);
        exp_rdata = 16'h0000;
        do_txn(0, 0, 0, 16'h0010, 16'h0000, 1, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Initiator side of the d16 data-memory bus. It accepts load/store requests from the CPU execute stage over a valid/ready handshake and drives the memory's en/write_enable/byte_enable/byte_select/addr/data_in lines. It honours mem_wait, captures read data one cycle after the registered-address access, and performs byte-lane extraction with optional sign extension. It sits between the CPU core and the mem block and owns all bus sequencing.

Parameters:
TIMEOUT, 255, max consecutive mem_wait cycles tolerated in one state before abort; 0 disables the timeout
TO_W, 8, width of the wait counter; must satisfy 2^TO_W > TIMEOUT

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  CPU request present
req_ready  out  1  controller can accept a request (high only in IDLE)
req_write  in  1  1 = store, 0 = load
req_byte  in  1  1 = byte access, 0 = word access
req_signed  in  1  byte loads only: 1 = sign-extend, 0 = zero-extend
req_addr  in  16  byte address
req_wdata  in  16  store data; byte stores use [7:0]
resp_valid  out  1  one-cycle pulse: access complete
resp_err  out  1  qualifies resp_valid: access aborted by timeout
resp_rdata  out  16  load result; held until the next load response
mem_en  out  1  to memory en
mem_write_enable  out  1  to memory write_enable
mem_byte_enable  out  1  to memory byte_enable
mem_byte_select  out  1  to memory byte_select (1 = upper lane [15:8])
mem_addr  out  16  word address to memory
mem_wdata  out  16  to memory data_in
mem_rdata  in  16  from memory data_out
mem_wait  in  1  memory stall

Behaviour:
- Reset: state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_en=0; mem_write_enable=0; mem_byte_enable=0; mem_byte_select=0; mem_addr=0; mem_wdata=0; wait counter=0.
- All mem_* outputs and resp_* outputs are registered.
- Address mapping: mem_addr={1'b0,req_addr[15:1]}; mem_byte_select=req_addr[0]. On word accesses, req_addr[0] is ignored for data but is still driven on mem_byte_select; the memory ignores it because byte_enable=0.
- Byte store: mem_wdata=req_wdata unchanged; memory writes [7:0] into the selected lane.
- States:
  - IDLE: on req_valid with req_ready, latch the request, load the mem_* registers, go to ACCESS.
  - ACCESS: mem_en=1. If mem_wait=1, stay and increment the counter. If mem_wait=0, clear the counter; a store goes to RESP, a load goes to READ.
  - READ: mem_en=0 (the memory holds its registered address). If mem_wait=1, stay and count. Otherwise capture the lane-extracted mem_rdata into resp_rdata and go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, then go to IDLE.
- Load extraction:
  - word: resp_rdata=mem_rdata.
  - byte: b = select ? mem_rdata[15:8] : mem_rdata[7:0]; resp_rdata = signed ? {{8{b[7]}},b} : {8'h00,b}.
- Latency with no wait, request accepted at edge E0:
  - mem_en is high for the cycle after E0.
  - store: resp_valid high in the 2nd cycle after E0.
  - load: resp_valid high in the 3rd cycle after E0.
  - Each mem_wait cycle adds one cycle.
- Timeout: if the counter reaches TIMEOUT while mem_wait=1 (TIMEOUT≠0), drop mem_en and go to RESP with resp_err=1. A timed-out load leaves resp_rdata unchanged. A store is not guaranteed to have been written.
- Store responses leave resp_rdata unchanged.
- Back-to-back requests: a new request can be accepted in the IDLE cycle after RESP. Minimum spacing is 3 cycles for stores and 4 for loads.
- req_valid with req_ready=0 is ignored. The CPU holds the request until it sees ready.
- Reset mid-operation: the next cycle is IDLE with every output at its reset value. No response is issued for the aborted access, and no mem_en is asserted after the reset edge.

Decomposition:
- Shared d16 memory-bus package/include holds the state encodings (IDLE, ACCESS, READ, RESP) and the lane constants LANE_LO=0 and LANE_HI=1. The mem block reuses the same package.
- One natural sub-module: mem_lane_extract, a combinational block from (rdata, byte, select, signed) to 16-bit result, reusable by a future instruction-fetch path.

Test Plan:
- Word store, addr 0x0010, data 0xBEEF, mem_wait=0 -> one mem_en cycle with mem_addr=0x0008, write_enable=1, byte_enable=0; resp_valid 2 cycles after accept; memory word 8 = 0xBEEF.
- Word load of word 8 after the store -> resp_valid 3 cycles after accept, resp_rdata=0xBEEF, resp_err=0.
- Byte store 0x12 to addr 0x0011, then signed byte load from 0x0011 -> mem_byte_select=1; word 8 = 0x12EF; load returns 0x0012.
- Signed byte load from addr 0x0010, then unsigned byte load from the same address -> signed returns 0xFFEF, unsigned returns 0x00EF.
- mem_wait held high for 3 cycles during ACCESS of a load -> mem_en high 4 cycles; resp_valid 3 cycles later than nominal; data correct.
- TIMEOUT=4 with mem_wait stuck high -> resp_valid with resp_err=1 after 4 wait cycles, resp_rdata unchanged. In a separate run, rst asserted in the READ state -> next cycle all outputs at reset values and no resp_valid.
